// File: rtl/regularni_fifo_arbiter_if.sv
// Bundle between the packet sources, the regular NI FIFO write port and the arbiter.
// The arbiter attaches via the slave modport; the sources/FIFO side uses master.
interface regularni_fifo_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*16-1:0] req_data;
  logic [NUM_REQ-1:0]    req_last;
  logic                  regularNI_FIFO_full;
  logic [NUM_REQ-1:0]    grant;
  logic [NUM_REQ-1:0]    ack;
  logic                  regularNI_FIFO_wr;
  logic [15:0]           regularFIFO_data;
  logic                  busy;
  logic [IDW-1:0]        cur_id;
  logic                  pkt_err;

  modport slave (
    input  req, req_data, req_last, regularNI_FIFO_full,
    output grant, ack, regularNI_FIFO_wr, regularFIFO_data, busy, cur_id, pkt_err
  );

  modport master (
    output req, req_data, req_last, regularNI_FIFO_full,
    input  grant, ack, regularNI_FIFO_wr, regularFIFO_data, busy, cur_id, pkt_err
  );
endinterface

// File: rtl/regularni_fifo_arbiter.sv
// Packet-atomic round-robin arbiter for the regular NI FIFO write port.
// Optional packet-length watchdog is enabled by defining REGNI_ARB_WATCHDOG_EN.
module regularni_fifo_arbiter_lane (
  input  logic        sel,
  input  logic [15:0] flit,
  output logic        ack,
  output logic [15:0] flit_gated
);
  assign ack        = sel;
  assign flit_gated = sel ? flit : 16'h0000;
endmodule

module regularni_fifo_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int IDW         = 2,
  parameter int MAX_PKT_LEN = 32
) (
  input logic                     clk_division,
  input logic                     rst,
  regularni_fifo_arbiter_if.slave bus
);
  if (NUM_REQ < 2 || NUM_REQ > 8)         begin : g_chk_num $error("NUM_REQ out of range"); end
  if ((2 ** IDW) < NUM_REQ)               begin : g_chk_idw $error("IDW too narrow"); end
  if (MAX_PKT_LEN < 1 || MAX_PKT_LEN > 255) begin : g_chk_len $error("MAX_PKT_LEN out of range"); end

  typedef enum logic {IDLE, XFER} state_t;

  state_t                    state, state_nxt;
  logic [NUM_REQ-1:0]        grant_q, grant_nxt;
  logic [IDW-1:0]            ptr, ptr_nxt, cur_id, cur_id_nxt;
  logic [IDW-1:0]            win_id, cand;
  logic                      win_vld;
  int                        scan_idx;
  logic [7:0]                flit_cnt, flit_cnt_nxt;
  logic                      pkt_err_q, pkt_err_nxt;
  logic                      xfer, own_last, wd_trip, release_port;
  logic [NUM_REQ-1:0]        lane_sel, lane_ack;
  logic [NUM_REQ-1:0][15:0]  lane_data;
  logic [15:0]               wr_data;

  // First requester after ptr wins, wrapping modulo NUM_REQ.
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    scan_idx = 0;
    cand     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (int'(ptr) + k) % NUM_REQ;
      cand     = IDW'(scan_idx);
      if (!win_vld && bus.req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  assign xfer     = !rst && (state == XFER) && bus.req[cur_id] && !bus.regularNI_FIFO_full;
  assign own_last = bus.req_last[cur_id];

`ifdef REGNI_ARB_WATCHDOG_EN
  // flit_cnt is pre-increment, so this fires on the MAX_PKT_LEN-th transfer.
  assign wd_trip = xfer && !own_last && (flit_cnt == 8'(MAX_PKT_LEN - 1));
`else
  assign wd_trip = 1'b0;
`endif

  assign release_port = xfer && (own_last || wd_trip);

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant_q;
    ptr_nxt      = ptr;
    cur_id_nxt   = cur_id;
    flit_cnt_nxt = flit_cnt;
    pkt_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt    = XFER;
          grant_nxt    = NUM_REQ'(1) << win_id;
          cur_id_nxt   = win_id;
          flit_cnt_nxt = 8'd0;
        end
      end
      XFER: begin
        if (xfer) flit_cnt_nxt = flit_cnt + 8'd1;
        if (release_port) begin
          state_nxt   = IDLE;
          grant_nxt   = '0;
          ptr_nxt     = cur_id;
          pkt_err_nxt = wd_trip;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_division or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      grant_q   <= '0;
      ptr       <= IDW'(NUM_REQ - 1);
      cur_id    <= '0;
      flit_cnt  <= 8'd0;
      pkt_err_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant_q   <= grant_nxt;
      ptr       <= ptr_nxt;
      cur_id    <= cur_id_nxt;
      flit_cnt  <= flit_cnt_nxt;
      pkt_err_q <= pkt_err_nxt;
    end
  end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane_sel[i] = xfer && grant_q[i];
    regularni_fifo_arbiter_lane u_lane (
      .sel        (lane_sel[i]),
      .flit       (bus.req_data[16*i +: 16]),
      .ack        (lane_ack[i]),
      .flit_gated (lane_data[i])
    );
  end

  always_comb begin
    wr_data = '0;
    for (int i = 0; i < NUM_REQ; i++) wr_data = wr_data | lane_data[i];
  end

  assign bus.grant             = grant_q;
  assign bus.ack               = lane_ack;
  assign bus.regularNI_FIFO_wr = xfer;
  assign bus.regularFIFO_data  = wr_data;
  assign bus.busy              = (state == XFER);
  assign bus.cur_id            = cur_id;
  assign bus.pkt_err           = pkt_err_q;
endmodule

// File: tb/tb_regularni_fifo_arbiter.sv
// Bench for regularni_fifo_arbiter: per-source flit queues feed the DUT and a
// packet-level reference model predicts every output each cycle.
module tb_regularni_fifo_arbiter;
  localparam int N = 4;
`ifdef REGNI_ARB_WATCHDOG_EN
  localparam int WD_LEN = 4;
`else
  localparam int WD_LEN = 32;
`endif

  logic clk_division = 1'b0;
  logic rst;
  always #5 clk_division = ~clk_division;

  regularni_fifo_arbiter_if #(.NUM_REQ(N), .IDW(2)) bus ();
  regularni_fifo_arbiter #(.NUM_REQ(N), .IDW(2), .MAX_PKT_LEN(WD_LEN)) dut (
    .clk_division (clk_division),
    .rst          (rst),
    .bus          (bus)
  );

  int total = 0;
  int bad   = 0;

  // source queues: {last, data}
  logic [16:0] srcq [N][$];
  bit [N-1:0]  en;
  bit          full;

  // reference model state
  bit m_busy;
  int m_owner, m_ptr, m_cur, m_cnt;
  bit m_err;

  // observation logs
  logic [15:0] wlog [$];
  int          glog [$];
  int          err_cnt, full_wr;
  bit          prev_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = N - 1; m_cur = 0; m_cnt = 0; m_err = 0;
    prev_busy = 0;
  endtask

  task automatic clear_src();
    for (int i = 0; i < N; i++) srcq[i].delete();
    en = '0; full = 0;
  endtask

  task automatic clear_logs();
    wlog.delete(); glog.delete(); err_cnt = 0; full_wr = 0;
  endtask

  task automatic push_pkt(input int s, input int len, input logic [15:0] base);
    for (int k = 0; k < len; k++) srcq[s].push_back({(k == len - 1), 16'(base + k)});
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (en[i] && srcq[i].size() > 0) begin
        bus.req[i] = 1'b1;
        bus.req_data[16*i +: 16] = srcq[i][0][15:0];
        bus.req_last[i] = srcq[i][0][16];
      end else begin
        bus.req[i] = 1'b0;
        bus.req_data[16*i +: 16] = 16'h0000;
        bus.req_last[i] = 1'b0;
      end
    end
    bus.regularNI_FIFO_full = full;
  endtask

  // One clock: drive, check at negedge against the model, advance the model.
  task automatic cycle();
    bit [N-1:0]  r;
    bit          xf, last, trip;
    logic [15:0] ed;
    logic [N-1:0] ea, eg;
    drive();
    @(negedge clk_division);
    for (int i = 0; i < N; i++) r[i] = en[i] && (srcq[i].size() > 0);
    xf = m_busy && r[m_owner] && !full;
    ed = xf ? srcq[m_owner][0][15:0] : 16'h0000;
    ea = xf ? (N'(1) << m_owner) : '0;
    eg = m_busy ? (N'(1) << m_owner) : '0;
    chk("grant", bus.grant, eg);
    chk("ack", bus.ack, ea);
    chk("wr", bus.regularNI_FIFO_wr, xf);
    chk("data", bus.regularFIFO_data, ed);
    chk("busy", bus.busy, m_busy);
    chk("cur_id", bus.cur_id, m_cur);
    chk("pkt_err", bus.pkt_err, m_err);
    if (bus.busy && !prev_busy) glog.push_back(int'(bus.cur_id));
    prev_busy = bus.busy;
    if (bus.regularNI_FIFO_wr) wlog.push_back(bus.regularFIFO_data);
    if (bus.pkt_err) err_cnt++;
    if (full && bus.regularNI_FIFO_wr) full_wr++;
    m_err = 0;
    if (!m_busy) begin
      if (|r) begin
        for (int k = 1; k <= N; k++) begin
          if (r[(m_ptr + k) % N]) begin m_owner = (m_ptr + k) % N; break; end
        end
        m_cur = m_owner; m_busy = 1; m_cnt = 0;
      end
    end else if (xf) begin
      last = srcq[m_owner][0][16];
      void'(srcq[m_owner].pop_front());
      m_cnt = (m_cnt + 1) % 256;
      trip = 0;
`ifdef REGNI_ARB_WATCHDOG_EN
      trip = !last && (m_cnt == WD_LEN);
`endif
      if (last || trip) begin m_busy = 0; m_ptr = m_owner; end
      m_err = trip;
    end
    @(posedge clk_division);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Asynchronous reset pulse mid-cycle; outputs must clear without a clock edge.
  task automatic async_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_grant"}, bus.grant, '0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_wr"}, bus.regularNI_FIFO_wr, 1'b0);
    chk({tag, "_ack"}, bus.ack, '0);
    model_reset();
    clear_src();
    drive();
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_wlog(input string tag, input logic [15:0] exp [$]);
    chk({tag, "_len"}, wlog.size(), exp.size());
    for (int k = 0; k < exp.size() && k < wlog.size(); k++) chk(tag, wlog[k], exp[k]);
  endtask

  task automatic chk_glog(input string tag, input int exp [$]);
    chk({tag, "_len"}, glog.size(), exp.size());
    for (int k = 0; k < exp.size() && k < glog.size(); k++) chk(tag, glog[k], exp[k]);
  endtask

  task automatic drain(input string tag);
    int n;
    bit pend;
    n = 0;
    en = '1; full = 0;
    do begin
      pend = m_busy;
      for (int i = 0; i < N; i++) if (srcq[i].size() > 0) pend = 1;
      if (pend) begin cycle(); n++; end
    end while (pend && n < 600);
    chk({tag, "_drained"}, (n < 600), 1'b1);
  endtask

  initial begin
    logic [15:0] ew [$];
    int          eg [$];
    int          cnt_a;

    rst = 1'b1;
    model_reset();
    clear_src();
    clear_logs();
    drive();
    repeat (2) @(negedge clk_division);
    chk("rst_grant", bus.grant, '0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_cur_id", bus.cur_id, 2'd0);
    chk("rst_wr", bus.regularNI_FIFO_wr, 1'b0);
    chk("rst_ack", bus.ack, '0);
    chk("rst_data", bus.regularFIFO_data, 16'h0000);
    chk("rst_pkt_err", bus.pkt_err, 1'b0);
    @(posedge clk_division); #1;
    rst = 1'b0;

    // single source, 3-flit packet
    srcq[0].push_back({1'b0, 16'h0012});
    srcq[0].push_back({1'b0, 16'hC001});
    srcq[0].push_back({1'b1, 16'hC002});
    en = 4'b0001;
    run(7);
    ew = '{16'h0012, 16'hC001, 16'hC002};
    chk_wlog("basic_flits", ew);
    eg = '{0};
    chk_glog("basic_grant", eg);

    // fairness with every source requesting
    async_reset("rst_fair");
    clear_logs();
    for (int s = 0; s < N; s++) push_pkt(s, 2, 16'(16'h1000 * (s + 1)));
    push_pkt(0, 2, 16'h1100);
    drain("fair");
    eg = '{0, 1, 2, 3, 0};
    chk_glog("fair_order", eg);
    ew = '{16'h1000, 16'h1001, 16'h2000, 16'h2001, 16'h3000, 16'h3001,
           16'h4000, 16'h4001, 16'h1100, 16'h1101};
    chk_wlog("fair_flits", ew);

    // FIFO full for 5 cycles mid-packet on source 2
    clear_logs();
    push_pkt(2, 4, 16'h2200);
    en = 4'b0100;
    run(2);
    full = 1;
    run(5);
    chk("full_no_wr", full_wr, 0);
    full = 0;
    run(5);
    ew = '{16'h2200, 16'h2201, 16'h2202, 16'h2203};
    chk_wlog("full_flits", ew);

    // owner drops req for 3 cycles while source 1 waits
    clear_logs();
    push_pkt(0, 3, 16'h5500);
    push_pkt(1, 2, 16'h6600);
    en = 4'b0001;
    run(2);
    en = 4'b0010;
    run(3);
    en = 4'b0011;
    run(8);
    ew = '{16'h5500, 16'h5501, 16'h5502, 16'h6600, 16'h6601};
    chk_wlog("drop_flits", ew);
    eg = '{0, 1};
    chk_glog("drop_grant", eg);

    // async reset during flit 2, then 0 wins first
    clear_logs();
    push_pkt(0, 3, 16'h7700);
    en = 4'b0001;
    run(2);
    drive();
    #1;
    chk("pre_rst_wr", bus.regularNI_FIFO_wr, 1'b1);
    async_reset("rst_mid");
    clear_logs();
    push_pkt(0, 1, 16'h8800);
    push_pkt(1, 1, 16'h9900);
    en = 4'b0011;
    run(6);
    eg = '{0, 1};
    chk_glog("post_rst_grant", eg);

    // long packet without tail on source 0, source 1 waiting
    async_reset("rst_wd");
    clear_logs();
    for (int k = 0; k < 6; k++) srcq[0].push_back({1'b0, 16'(16'hA000 + k)});
    push_pkt(1, 2, 16'hB000);
    en = 4'b0011;
    run(16);
    cnt_a = 0;
    foreach (wlog[k]) if (wlog[k][15:12] == 4'hA) cnt_a++;
    chk("wd_src0_writes", cnt_a, 6);
`ifdef REGNI_ARB_WATCHDOG_EN
    chk("wd_err_pulses", err_cnt, 1);
    eg = '{0, 1, 0};
`else
    chk("wd_err_pulses", err_cnt, 0);
    eg = '{0};
`endif
    chk_glog("wd_grant", eg);
    async_reset("rst_rand");

    // randomized traffic with random enables and FIFO backpressure
    clear_logs();
    for (int c = 0; c < 400; c++) begin
      int s;
      s = int'($urandom_range(0, N - 1));
      if ($urandom_range(0, 2) == 0 && srcq[s].size() < 8)
        push_pkt(s, int'($urandom_range(1, 5)), 16'(16'h1000 * s + c * 8));
      for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 3) != 0);
      full = ($urandom_range(0, 3) == 0);
      cycle();
    end
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regularni_fifo_arbiter.md
Name: regularni_fifo_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares the single regular NI FIFO write port among NUM_REQ packet sources (sensor samplers, traffic generators).
- Each source presents 16-bit flits with a last-flit marker. Once a source is granted, it keeps the port until its tail flit is written.
- Sits between the per-core write controllers and the regular NI FIFO, and honours the FIFO full flag.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- IDW, 2, width of cur_id; must satisfy 2**IDW >= NUM_REQ
- MAX_PKT_LEN, 32, flit limit per packet; used only with REGNI_ARB_WATCHDOG_EN (1..255)

Ports:
- clk_division  input  1  block clock (divided clock)
- rst  input  1  asynchronous reset, active-high
- req  input  NUM_REQ  per-source flit valid; source holds its data and last stable until acked
- req_data  input  NUM_REQ*16  flit of source i on bits [16i+15:16i]
- req_last  input  NUM_REQ  flit of source i is the packet tail
- regularNI_FIFO_full  input  1  FIFO cannot accept a write this cycle
- grant  output  NUM_REQ  one-hot owner of the port; all zero when idle
- ack  output  NUM_REQ  flit of source i consumed this cycle (combinational)
- regularNI_FIFO_wr  output  1  FIFO write strobe (combinational)
- regularFIFO_data  output  16  FIFO write data (combinational)
- busy  output  1  high in XFER state
- cur_id  output  IDW  index of granted source; holds last owner when idle
- pkt_err  output  1  one-cycle pulse when a packet is truncated by the watchdog

Behaviour:
- Reset values: state IDLE, grant 0, busy 0, cur_id 0, rr pointer NUM_REQ-1 (source 0 has first priority), flit_cnt 0, pkt_err 0.
- Combinational outputs (ack, regularNI_FIFO_wr, regularFIFO_data) are 0 during reset.
- IDLE state:
  - No writes are issued.
  - If any req bit is high, the winner is the first set bit scanning ptr+1, ptr+2, ... modulo NUM_REQ.
  - On the next edge: grant is set to the winner (one-hot), cur_id is set to its index, state goes to XFER, flit_cnt is cleared.
  - Arbitration therefore costs one cycle; the first flit can be written at the earliest in the cycle after req rises.
- XFER state, with granted index g:
  - A transfer occurs when req[g] is high and regularNI_FIFO_full is low.
  - On a transfer: regularNI_FIFO_wr = 1, regularFIFO_data = req_data[g], ack[g] = 1, and all other ack bits are 0.
  - With no transfer: wr = 0, data = 16'h0000, ack = 0.
  - On every transfer, flit_cnt increments (8-bit, wraps at 255 when the watchdog is off).
  - If the transferred flit has req_last[g] set: on the next edge, state goes to IDLE, grant clears, and ptr is set to g.
  - The next arbitration happens in IDLE, so there is at least one idle cycle between packets.
- If req[g] drops mid-packet, the grant is held and bubbles are inserted. Other requesters wait; no flit of another source is ever interleaved.
- FIFO full while granted: the write is stalled, ack stays 0, and the source must hold its data.
- Requests that are raised or dropped in XFER by non-owners are ignored until the next IDLE.
- Single-flit packet (req_last on the first flit): the transfer happens and the block returns to IDLE.
- Asynchronous reset mid-packet: immediate return to IDLE with reset values. The partial packet is not completed; the FIFO contents are not the arbiter's concern.
- Fairness: with all sources continuously requesting, grants follow the order 0,1,2,3,0,...

Optional Feature:
- Macro REGNI_ARB_WATCHDOG_EN.
- Defined:
  - If flit_cnt reaches MAX_PKT_LEN on a transfer whose req_last is 0, the arbiter releases the port as if that flit were the tail (state to IDLE, ptr set to g).
  - pkt_err pulses high for exactly one cycle, in the cycle after that transfer.
  - A tail flit arriving exactly at MAX_PKT_LEN is normal; no error is raised.
- Undefined: no length limit, pkt_err tied to 0.

Test Plan:
- Reset, then req=4'b0001 with a 3-flit packet (0x0012, 0xC001, 0xC002 with last) -> grant=0001 one cycle after req; wr high for 3 cycles with exactly those values; grant returns to 0 after the tail; busy tracks.
- req=4'b1111 continuously, 2-flit packets per source -> packet order 0,1,2,3,0; no flit interleaving; one idle cycle between packets.
- Source 2 granted, regularNI_FIFO_full held high for 5 cycles mid-packet -> wr=0 and ack=0 for those 5 cycles, data resumes with the held flit, no flit lost or duplicated.
- Owner drops req for 3 cycles mid-packet while source 1 requests -> grant stays with the owner, source 1 gets no ack until the owner's tail is written.
- Assert rst asynchronously during flit 2 of a packet -> grant, busy and wr go to 0 immediately; after release, req=4'b0011 grants source 0 first.
- With REGNI_ARB_WATCHDOG_EN and MAX_PKT_LEN=4, source feeds 6 flits without last -> 4 writes, then release, one-cycle pkt_err pulse, next source granted; without the macro -> all 6 flits written and pkt_err stays 0.
